decode_rf_stage: RTL
====================

DECODE_RF_STAGE -- requirements
Module: decode_rf_stage

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the register and operand width in bits (legal 16..64).
REQ-002 The module SHALL have parameter NREGS, default 32, giving the register count (legal 8, 16, 32); fields are indexed by their low log2(NREGS) bits.
REQ-003 The module SHALL have parameter INIT_BASE, default 10, giving the reset value base; register i resets to INIT_BASE+i.
REQ-004 The module SHALL have parameter ZERO_REG, default 0; when 1, register 0 reads 0 and ignores writes.
REQ-005 Ports, in order (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- instruction  in  32  [31:25] opcode, [24:20] dst, [19:15] src1, [14:10] src2, [9:0] offsetlo
- flush  in  1  discard held instruction
- wb_en  in  1  register write strobe
- wb_addr  in  5  write index
- wb_data  in  XLEN  write data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts
- opcode  out  7;  dst  out  5;  src1_reg  out  5;  src2_reg  out  5
- src1  out  XLEN;  src2  out  XLEN
- offsetlo  out  10  raw field
- imm  out  XLEN  offsetlo sign-extended from bit 9

Function
REQ-006 The stage SHALL be a single valid/ready pipeline register; in_ready = !out_valid || out_ready (combinational).
REQ-007 A transfer in SHALL occur on a rising edge with in_valid && in_ready && !flush; all output fields load from instruction that edge, out_valid set to 1.
REQ-008 src1_reg SHALL be instruction[19:15] and src2_reg SHALL be instruction[14:10].
REQ-009 An edge with out_valid && out_ready and no transfer in SHALL clear out_valid; output fields hold their last values.
REQ-010 While out_valid && !out_ready, all output fields SHALL hold except as REQ-013 states.
REQ-011 The register file SHALL write wb_data to wb_addr on any rising edge with wb_en, independent of handshake and flush state.
REQ-012 Write-through bypass: on a transfer-in edge, an operand whose index equals wb_addr with wb_en high SHALL load wb_data, not the stale register value.
REQ-013 Stall refresh: when out_valid && !out_ready and wb_en with wb_addr equal to src1_reg (src2_reg), src1 (src2) SHALL load wb_data that edge; both update if both match.
REQ-014 ZERO_REG=1: index 0 reads 0 in REQ-012/013 as well; writes to 0 are dropped and never bypassed.
REQ-015 flush high SHALL clear out_valid on that edge and block any transfer in that edge; register-file writes still occur.
REQ-016 Index bits above log2(NREGS) SHALL be ignored for both reads and writes; output *_reg fields carry the full 5-bit field.
REQ-017 Latency SHALL be exactly one cycle from accepted instruction to out_valid; throughput one instruction per cycle with out_ready held high.

Reset
REQ-018 rst_n low SHALL asynchronously force out_valid=0, opcode/dst/src1_reg/src2_reg/offsetlo=0, src1/src2/imm=0, and register i=INIT_BASE+i (register 0=0 if ZERO_REG).
REQ-019 After rst_n deasserts, the first edge SHALL be able to accept an instruction; reset during a stall SHALL discard the held instruction.

Verification
REQ-020 Reset, instruction with src1=3, src2=7, offsetlo=10'h3FF, in_valid=1, out_ready=1 -> next cycle out_valid=1, src1=13, src2=17, imm=all-ones, src2_reg=7.
REQ-021 Same edge wb_en=1, wb_addr=5, wb_data=99, instruction src1=5 -> src1=99; later read of r5 also 99.
REQ-022 out_ready=0 with held src2_reg=4, then wb_en write r4=55 -> src2 becomes 55 while out_valid stays 1, in_ready=0; others unchanged.
REQ-023 Back-to-back 8 instructions, out_ready toggling 1/0 -> every instruction appears exactly once, in order, none duplicated or dropped.
REQ-024 flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming instruction not captured.
REQ-025 ZERO_REG=1, NREGS=16: write r0=7, read r0 -> 0; read index 17 -> returns register 1 value (11).

Source files
------------

// File: rtl/decode_rf_stage.sv
// Decode / register-read stage: one valid/ready pipeline register in front of a
// register file with write-through bypass and stall-time operand refresh.
module decode_rf_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned INIT_BASE = 10,
  parameter bit          ZERO_REG  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      dst,
  output logic [4:0]      src1_reg,
  output logic [4:0]      src2_reg,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [9:0]      offsetlo,
  output logic [XLEN-1:0] imm
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] r_rf [NREGS];

  logic [AW-1:0]   w_wa;
  logic [AW-1:0]   w_s1a;
  logic [AW-1:0]   w_s2a;
  logic            w_wr_ok;
  logic            w_xfer;
  logic            w_stall;
  logic            w_ref1;
  logic            w_ref2;
  logic [XLEN-1:0] w_s1_val;
  logic [XLEN-1:0] w_s2_val;
  logic [XLEN-1:0] w_imm;
  logic            w_unused_hi;

  // Upper index bits only matter for the full-width *_reg outputs.
  assign w_unused_hi = ^wb_addr;

  assign w_wa  = wb_addr[AW-1:0];
  assign w_s1a = instruction[15 +: AW];
  assign w_s2a = instruction[10 +: AW];

  // Writes to a hard-wired zero register are dropped, so they never bypass either.
  assign w_wr_ok = wb_en && !(ZERO_REG && (w_wa == '0));

  assign in_ready = !out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready && !flush;
  assign w_stall  = out_valid && !out_ready;

  assign w_ref1 = w_wr_ok && (w_wa == src1_reg[AW-1:0]);
  assign w_ref2 = w_wr_ok && (w_wa == src2_reg[AW-1:0]);

  assign w_imm = {{(XLEN-10){instruction[9]}}, instruction[9:0]};

  // Operand read with write-through bypass of a same-edge write.
  always_comb begin
    w_s1_val = r_rf[w_s1a];
    w_s2_val = r_rf[w_s2a];
    if (ZERO_REG && (w_s1a == '0)) w_s1_val = '0;
    if (ZERO_REG && (w_s2a == '0)) w_s2_val = '0;
    if (w_wr_ok && (w_wa == w_s1a)) w_s1_val = wb_data;
    if (w_wr_ok && (w_wa == w_s2a)) w_s2_val = wb_data;
  end

  // Register file: written on any strobe regardless of handshake or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_rf[i] <= (ZERO_REG && (i == 0)) ? '0 : XLEN'(INIT_BASE + i);
      end
    end else if (w_wr_ok) begin
      r_rf[w_wa] <= wb_data;
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      opcode    <= '0;
      dst       <= '0;
      src1_reg  <= '0;
      src2_reg  <= '0;
      offsetlo  <= '0;
      src1      <= '0;
      src2      <= '0;
      imm       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_xfer) begin
      out_valid <= 1'b1;
      opcode    <= instruction[31:25];
      dst       <= instruction[24:20];
      src1_reg  <= instruction[19:15];
      src2_reg  <= instruction[14:10];
      offsetlo  <= instruction[9:0];
      src1      <= w_s1_val;
      src2      <= w_s2_val;
      imm       <= w_imm;
    end else if (w_stall) begin
      // Keep held operands coherent with writes that land while stalled.
      if (w_ref1) src1 <= wb_data;
      if (w_ref2) src2 <= wb_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
